// File: rtl/dcim_pkg.sv
// Shared definitions for the DCIM output stage: FSM state encodings and the
// beat-counter width helper.
package dcim_pkg;

  // Legacy-compatible state encodings for the shift-accumulator FSM.
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StAcc  = 2'd1;
  localparam logic [1:0] StHold = 2'd2;

  // Width of a counter that must hold values 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/se_acc_lane.sv
// One lane of the sign-extending shift-accumulator: sign extension, shift,
// add/negate datapath and the accumulator register.
// Optional saturation with sticky overflow flag when ACC_SAT_EN is defined;
// otherwise the sum wraps modulo 2^ACC_W and ovf_o is tied low.
module se_acc_lane #(
  parameter int unsigned IN_W  = 27,
  parameter int unsigned ACC_W = 51
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             first_i,  // accepted MSB beat: overwrite accumulator
  input  logic             beat_i,   // accepted later beat: shift and add
  input  logic             neg_i,    // MSB beat carries negative weight
  input  logic [IN_W-1:0]  psum_i,
  output logic [ACC_W-1:0] acc_o,
  output logic             ovf_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] ext, shl, sum;

  assign ext = {{(ACC_W - IN_W){psum_i[IN_W-1]}}, psum_i};
  assign shl = acc_q << 1;
  assign sum = shl + ext;

`ifdef ACC_SAT_EN
  logic ovf_q, ovf_d;
  logic shift_ovf, add_ovf, true_neg;

  // Next accumulator with clamping; a saturated lane holds its clamp value.
  always_comb begin
    shift_ovf = acc_q[ACC_W-1] ^ acc_q[ACC_W-2];
    add_ovf   = (shl[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != shl[ACC_W-1]);
    // A lost shift bit dominates: |p| is too small to pull the value back in range.
    true_neg  = shift_ovf ? acc_q[ACC_W-1] : shl[ACC_W-1];
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    if (first_i) begin
      acc_d = neg_i ? -ext : ext;
      ovf_d = 1'b0;
    end else if (beat_i) begin
      if (ovf_q) begin
        acc_d = acc_q;
      end else if (shift_ovf || add_ovf) begin
        acc_d = true_neg ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        ovf_d = 1'b1;
      end else begin
        acc_d = sum;
      end
    end
  end

  // Sticky overflow flag, cleared by the next first beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf_o = ovf_q;
`else
  // Next accumulator, wrapping modulo 2^ACC_W.
  always_comb begin
    acc_d = acc_q;
    if (first_i)     acc_d = neg_i ? -ext : ext;
    else if (beat_i) acc_d = sum;
  end

  assign ovf_o = 1'b0;
`endif

  // Accumulator register; holds through gaps, HOLD and IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/se_shift_acc.sv
// Multi-lane sign-extending shift-accumulator for bit-serial DCIM outputs.
// One signed partial sum per lane per beat, MSB beat first; after NBITS beats
// the per-lane result is held on a valid/ready output.
// Define ACC_SAT_EN to enable per-lane saturation and out_ovf flags.
module se_shift_acc
  import dcim_pkg::*;
#(
  parameter int unsigned IN_W  = 27,
  parameter int unsigned ACC_W = 51,
  parameter int unsigned NBITS = 8,
  parameter int unsigned CH    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH*IN_W-1:0]  in_psum,
  input  logic              in_signed,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH*ACC_W-1:0] out_sum,
  output logic [CH-1:0]     out_ovf,
  output logic              busy
);

  localparam int unsigned   CntW    = cnt_width(NBITS);
  localparam logic [CntW-1:0] CntLast = CntW'(NBITS - 1);

  if (ACC_W < IN_W + 1) begin : g_bad_acc_w
    $error("se_shift_acc: ACC_W must be at least IN_W+1");
  end
  if (NBITS < 2) begin : g_bad_nbits
    $error("se_shift_acc: NBITS must be at least 2");
  end

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            first_beat, next_beat;

  assign in_ready   = (state_q != StHold);
  assign out_valid  = (state_q == StHold);
  assign busy       = (state_q != StIdle);
  assign first_beat = in_valid && (state_q == StIdle);
  assign next_beat  = in_valid && (state_q == StAcc);

  // FSM and beat counter next-state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = StAcc;
          cnt_d   = CntW'(1);
        end
      end
      StAcc: begin
        if (in_valid) begin
          if (cnt_q == CntLast) begin
            state_d = StHold;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StHold: begin
        if (out_ready) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM and beat counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // in_signed only matters on the first beat, so it feeds the lanes directly
  // and later changes have no effect.
  for (genvar i = 0; i < CH; i++) begin : g_lane
    se_acc_lane #(
      .IN_W  (IN_W),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .first_i (first_beat),
      .beat_i  (next_beat),
      .neg_i   (in_signed),
      .psum_i  (in_psum[i*IN_W +: IN_W]),
      .acc_o   (out_sum[i*ACC_W +: ACC_W]),
      .ovf_o   (out_ovf[i])
    );
  end

endmodule
